// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR flash read controller.
// Contents: flash opcodes, address/dummy field widths and the controller
// state encoding used by spi_flash_read_ctrl.
package spi_flash_pkg;

  localparam logic [7:0]  OPC_READ      = 8'h03;
  localparam logic [7:0]  OPC_FAST_READ = 8'h0B;
  localparam int unsigned ADDR_BITS     = 24;
  localparam int unsigned DUMMY_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period timer for the SPI read controller.
// Ports:
//   clk, rst  - clock, synchronous active-low reset
//   clr       - restart the timer: counter to 0, phase back to SCK-low
//   en        - count while high
//   tick_c    - one-cycle strobe: an SCK edge is due on the next clk edge
//   rise_c    - tick_c for a low-to-high SCK edge
//   fall_c    - tick_c for a high-to-low SCK edge
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DIV_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick_c,
  output logic rise_c,
  output logic fall_c
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Phase tracks the SCK level the next tick will leave behind.
  always_comb begin
    tick_c  = en && (cnt_q == DIV_W'(CLK_DIV - 1));
    rise_c  = tick_c && !phase_q;
    fall_c  = tick_c && phase_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (en) begin
      if (tick_c) begin
        cnt_d   = '0;
        phase_d = !phase_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_flash_read_ctrl.sv
// Single-lane SPI mode-0 read sequencer for serial NOR flash:
// opcode, 24-bit address, (optional dummy byte), then req_len data bytes.
// Build option: define SPI_FAST_READ_EN to issue FAST_READ (0x0B) with
// 8 dummy clocks; otherwise READ (0x03) with no dummy clocks.
// Ports:
//   clk, rst                  - clock, synchronous active-low reset
//   req_valid/req_ready       - request handshake (one request at a time)
//   req_addr, req_len         - flash byte address, byte count (0 = no bus cycle)
//   rd_data, rd_valid         - received byte and its one-cycle strobe
//   done, busy                - completion pulse, transaction in progress
//   spi_cs_n/sck/mosi/miso    - flash pins
module spi_flash_read_ctrl
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned CS_HIGH_MIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             busy,
  output logic             spi_cs_n,
  output logic             spi_sck,
  output logic             spi_mosi,
  input  logic             spi_miso
);

`ifdef SPI_FAST_READ_EN
  localparam int unsigned HDR_BITS = 8 + ADDR_BITS + DUMMY_BITS;
`else
  localparam int unsigned HDR_BITS = 8 + ADDR_BITS;
`endif
  localparam int unsigned HCNT_W = $clog2(HDR_BITS + 1);
  localparam int unsigned GAP_W  = (CS_HIGH_MIN > 1) ? $clog2(CS_HIGH_MIN) : 1;

  logic [HDR_BITS-1:0] hdr_c;
`ifdef SPI_FAST_READ_EN
  assign hdr_c = {OPC_FAST_READ, req_addr, DUMMY_BITS'(0)};
`else
  assign hdr_c = {OPC_READ, req_addr};
`endif

  state_e              state_q, state_d;
  logic [HDR_BITS-1:0] tx_q, tx_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [7:0]          rx_q, rx_d;
  logic                pend_q, pend_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                req_ready_q, req_ready_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                cs_n_q, cs_n_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;

  logic sck_clr_c, sck_en_c, tick_c, rise_c, fall_c, data_ph_c;

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_sck_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (sck_clr_c),
    .en     (sck_en_c),
    .tick_c (tick_c),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    hcnt_d      = hcnt_q;
    bit_d       = bit_q;
    len_d       = len_q;
    rx_d        = rx_q;
    pend_d      = 1'b0;
    gap_d       = gap_q;
    req_ready_d = req_ready_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    sck_clr_c   = 1'b0;
    sck_en_c    = (state_q == SHIFT) || (state_q == HOLD);
    data_ph_c   = (hcnt_q == HCNT_W'(HDR_BITS));

    // A completed byte is published one cycle after the sampling edge.
    if (pend_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rx_q;
    end

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          len_d       = req_len;
          hcnt_d      = '0;
          bit_d       = '0;
          tx_d        = hdr_c;
          if (req_len == '0) begin
            // Skip the bus entirely; the single GAP cycle carries done.
            state_d = GAP;
            gap_d   = GAP_W'(CS_HIGH_MIN - 1);
            done_d  = 1'b1;
          end else begin
            state_d   = SHIFT;
            cs_n_d    = 1'b0;
            sck_d     = 1'b0;
            mosi_d    = hdr_c[HDR_BITS-1];
            sck_clr_c = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (rise_c) begin
          sck_d = 1'b1;
          if (data_ph_c) begin
            rx_d = {rx_q[6:0], spi_miso};
            if (bit_q == 3'd7) begin
              pend_d = 1'b1;
              len_d  = len_q - LEN_W'(1);
            end
          end
        end else if (fall_c) begin
          sck_d = 1'b0;
          if (!data_ph_c) begin
            // Zeros shift in behind the header, so mosi idles low for data.
            tx_d   = {tx_q[HDR_BITS-2:0], 1'b0};
            mosi_d = tx_q[HDR_BITS-2];
            hcnt_d = hcnt_q + HCNT_W'(1);
          end else begin
            bit_d = bit_q + 3'd1;
            if ((bit_q == 3'd7) && (len_q == '0)) begin
              state_d = HOLD;
            end
          end
        end
      end

      HOLD: begin
        if (tick_c) begin
          cs_n_d  = 1'b1;
          state_d = GAP;
          gap_d   = '0;
          if (CS_HIGH_MIN == 1) begin
            done_d = 1'b1;
          end
        end
      end

      GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (32'(gap_q) + 32'd2 == CS_HIGH_MIN) begin
          done_d = 1'b1;
        end
        if (32'(gap_q) + 32'd1 == CS_HIGH_MIN) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      hcnt_q      <= '0;
      bit_q       <= '0;
      len_q       <= '0;
      rx_q        <= '0;
      pend_q      <= 1'b0;
      gap_q       <= '0;
      req_ready_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      hcnt_q      <= hcnt_d;
      bit_q       <= bit_d;
      len_q       <= len_d;
      rx_q        <= rx_d;
      pend_q      <= pend_d;
      gap_q       <= gap_d;
      req_ready_q <= req_ready_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;

endmodule
